console_blit_ctrl: RTL and testbench
====================================

CONSOLE_BLIT_CTRL -- requirements
Module: console_blit_ctrl

Interface
REQ-001 clk  input  1  single clock for all logic.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 a  input  32  register address; a[4:2] selects: 0 CMD, 1 FILL, 2 STATUS.
REQ-004 d  input  32  register write data.
REQ-005 we  input  1  register write strobe, one cycle per write.
REQ-006 spo  output  32  registered read data: STATUS when a[4:2]==2, otherwise 0.
REQ-007 char_a / char_d / char_we  input  12 / 16 / 1  CPU direct cell write {attr[15:8], code[7:0]}.
REQ-008 ram_wa / ram_wd / ram_we  output  12 / 16 / 1  write port to the 80x30 char RAM.
REQ-009 ram_ra  output  12  engine read address.
REQ-010 ram_rd  input  16  read data; valid exactly 1 cycle after ram_ra is driven.
REQ-011 busy  output  1  high while a command executes.
REQ-012 done  output  1  one-cycle pulse when a command completes.

Function
REQ-013 The cell address is row*80+col; the valid range is 0..2399, and the engine never drives an address above 2399.
REQ-014 CMD write fields: d[1:0] op (00 NOP, 01 CLEAR, 10 SCROLL, 11 FILLROW) and d[12:8] n (row count or row index).
REQ-015 FILL register holds the 16-bit fill word; reset value 16'h0F20 (space, white on black).
REQ-016 CLEAR writes the fill word to cells 0..2399 in ascending order.
REQ-017 SCROLL n, 1<=n<=29: cell (r,c) receives the old (r+n,c) for r in 0..29-n, ascending; the last n rows receive the fill word.
REQ-018 SCROLL n=0 completes with no RAM writes, and done pulses the cycle after the CMD write.
REQ-019 SCROLL n>=30 behaves as CLEAR.
REQ-020 FILLROW r writes the fill word to the 80 cells of row r; r>=30 performs no write, and done pulses the next cycle.
REQ-021 A CMD write while busy is ignored and sets sticky STATUS.cmd_err.
REQ-022 A NOP CMD has no effect.
REQ-023 FSM states: IDLE, COPY_RD, COPY_WR, FILL, DONE.
REQ-024 IDLE->COPY_RD for SCROLL; IDLE->FILL for CLEAR/FILLROW.
REQ-025 COPY_RD drives ram_ra=src; COPY_WR writes ram_rd to dst; COPY_WR->COPY_RD until the copy range is exhausted, then ->FILL.
REQ-026 FILL writes one cell per cycle; after the last cell FILL->DONE; DONE asserts done and returns to IDLE.
REQ-027 Uncontended throughput: copy 2 cycles/cell, fill 1 cycle/cell; CLEAR takes exactly 2400 write cycles plus one DONE cycle.
REQ-028 A CPU direct write enters a one-entry buffer that has priority for the RAM write port in IDLE, COPY_RD and FILL cycles.
REQ-029 A granted CPU write freezes all engine state for that cycle.
REQ-030 In COPY_WR cycles the engine always owns the write port.
REQ-031 In IDLE with an empty buffer, a CPU write reaches the RAM port 1 cycle after char_we.
REQ-032 A char_we arriving while the buffer is full and not draining that cycle is dropped and sets sticky STATUS.ovf.
REQ-033 A char_we in the same cycle the buffer drains is accepted.
REQ-034 STATUS layout: [0] busy, [1] ovf, [2] cmd_err.
REQ-035 Writing STATUS with d[1] or d[2] set clears the corresponding sticky bit; a simultaneous set event wins.
REQ-036 busy rises the cycle after an accepted CMD write and falls in the same cycle as done.

Reset
REQ-037 While rst_n is low, all outputs are 0, the FSM is in IDLE, the buffer is empty, sticky bits are 0, and FILL is 16'h0F20.
REQ-038 Reset asserted mid-command aborts the command immediately, with no done pulse; partially updated RAM contents are left as is.

Structure
REQ-039 Package quasi_console_pkg holds COLS=80, ROWS=30, CELLS=2400, the op encodings, the register offsets, and the FSM state enum.
REQ-040 The one-entry CPU write buffer is the sub-module console_wbuf (valid/addr/data, push, pop, full).
REQ-041 All remaining logic (FSM, src/dst/count counters, port mux) resides in console_blit_ctrl.

Verification
REQ-042 FILL=16'h1741, CMD=CLEAR -> 2400 writes of 16'h1741 to addresses 0..2399 in order; done after 2401 cycles; busy high throughout.
REQ-043 RAM model cell k=k, SCROLL n=2 -> cell k holds k+160 for k<2240, cells 2240..2399 hold FILL; done once.
REQ-044 SCROLL n=0 -> zero ram_we, done next cycle; SCROLL n=31 -> identical to CLEAR.
REQ-045 During CLEAR, char_we to addr 5 with 16'hABCD -> written on the next FILL cycle; total duration grows by exactly 1 cycle.
REQ-046 Two consecutive char_we during COPY_WR/COPY_RD back-to-back -> second accepted only if the buffer drained, else ovf=1; STATUS write with d[1]=1 -> ovf=0.
REQ-047 CMD while busy -> cmd_err=1, running command unaffected; rst_n low mid-SCROLL -> ram_we=0 immediately, busy=0, no done.

Source files
------------

// File: rtl/console_blit_ctrl_pkg.sv
// Shared constants, register map and FSM state encoding for the console blitter.
// The char RAM is 80x30 cells; each cell is {attr[15:8], code[7:0]}.
package quasi_console_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned CELLS  = 2400;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] LAST_CELL  = 12'd2399;
    localparam logic [ADDR_W-1:0] ROW_LAST   = 12'd79;
    localparam logic [4:0]        ROWS_L     = 5'd30;
    localparam logic [DATA_W-1:0] FILL_RESET = 16'h0F20;

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_CLEAR   = 2'b01;
    localparam logic [1:0] OP_SCROLL  = 2'b10;
    localparam logic [1:0] OP_FILLROW = 2'b11;

    localparam logic [2:0] REG_CMD    = 3'd0;
    localparam logic [2:0] REG_FILL   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COPY_RD,
        ST_COPY_WR,
        ST_FILL,
        ST_DONE
    } state_t;

    // row*80 computed as row*64 + row*16
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] r);
        return {1'b0, r, 6'b0} + {3'b0, r, 4'b0};
    endfunction

endpackage

// File: rtl/console_blit_ctrl_wbuf.sv
// One-entry buffer holding a pending CPU cell write until the RAM port is free.
module console_wbuf
    import quasi_console_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (push_i) begin
            valid_d = 1'b1;
            addr_d  = addr_i;
            data_d  = data_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign full_o  = valid_q;

endmodule

// File: rtl/console_blit_ctrl.sv
// Text-console blit engine: CLEAR / SCROLL / FILLROW over an 80x30 char RAM,
// sharing the RAM write port with buffered CPU direct cell writes.
module console_blit_ctrl
    import quasi_console_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    input  logic [11:0] char_a,
    input  logic [15:0] char_d,
    input  logic        char_we,
    output logic [11:0] ram_wa,
    output logic [15:0] ram_wd,
    output logic        ram_we,
    output logic [11:0] ram_ra,
    input  logic [15:0] ram_rd,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [11:0] src_q, src_d;
    logic [11:0] dst_q, dst_d;
    logic [11:0] last_q, last_d;
    logic [15:0] fill_q, fill_d;
    logic        ovf_q, ovf_d;
    logic        cmd_err_q, cmd_err_d;
    logic [31:0] spo_q, spo_d;

    logic        wb_valid, wb_full, wb_push, wb_pop;
    logic [11:0] wb_addr;
    logic [15:0] wb_data;
    logic        grant;

    logic [2:0]  reg_sel;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_n;
    logic        cmd_wr, cmd_accept, sts_wr, engine_busy;

    logic unused_bits;
    assign unused_bits = ^{a[31:5], a[1:0], d[31:16]};

    assign reg_sel     = a[4:2];
    assign cmd_op      = d[1:0];
    assign cmd_n       = d[12:8];
    assign cmd_wr      = we && (reg_sel == REG_CMD);
    assign sts_wr      = we && (reg_sel == REG_STATUS);
    assign engine_busy = (state_q == ST_COPY_RD) || (state_q == ST_COPY_WR) ||
                         (state_q == ST_FILL);
    assign cmd_accept  = cmd_wr && !engine_busy;

    // CPU writes win the port everywhere except COPY_WR, whose read data is only valid now
    assign grant   = wb_valid && (state_q != ST_COPY_WR);
    assign wb_pop  = grant;
    assign wb_push = char_we && (!wb_full || wb_pop);

    console_wbuf u_wbuf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wb_push),
        .pop_i   (wb_pop),
        .addr_i  (char_a),
        .data_i  (char_d),
        .valid_o (wb_valid),
        .addr_o  (wb_addr),
        .data_o  (wb_data),
        .full_o  (wb_full)
    );

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        last_d  = last_q;
        ram_we  = 1'b0;
        ram_wa  = '0;
        ram_wd  = '0;
        ram_ra  = '0;

        if (grant) begin
            ram_we = 1'b1;
            ram_wa = wb_addr;
            ram_wd = wb_data;
        end

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (cmd_accept) begin
                    case (cmd_op)
                        OP_CLEAR: begin
                            dst_d   = '0;
                            last_d  = LAST_CELL;
                            state_d = ST_FILL;
                        end
                        OP_SCROLL: begin
                            if (cmd_n == 5'd0) begin
                                state_d = ST_DONE;
                            end else if (cmd_n >= ROWS_L) begin
                                dst_d   = '0;
                                last_d  = LAST_CELL;
                                state_d = ST_FILL;
                            end else begin
                                src_d   = row_base(cmd_n);
                                dst_d   = '0;
                                last_d  = LAST_CELL;
                                state_d = ST_COPY_RD;
                            end
                        end
                        OP_FILLROW: begin
                            if (cmd_n >= ROWS_L) begin
                                state_d = ST_DONE;
                            end else begin
                                dst_d   = row_base(cmd_n);
                                last_d  = row_base(cmd_n) + ROW_LAST;
                                state_d = ST_FILL;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_COPY_RD: begin
                ram_ra = src_q;
                if (!grant) state_d = ST_COPY_WR;
            end
            ST_COPY_WR: begin
                ram_we = 1'b1;
                ram_wa = dst_q;
                ram_wd = ram_rd;
                dst_d  = dst_q + 12'd1;
                src_d  = src_q + 12'd1;
                state_d = (src_q == LAST_CELL) ? ST_FILL : ST_COPY_RD;
            end
            ST_FILL: begin
                if (!grant) begin
                    ram_we = 1'b1;
                    ram_wa = dst_q;
                    ram_wd = fill_q;
                    dst_d  = dst_q + 12'd1;
                    if (dst_q == last_q) state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fill_d    = fill_q;
        ovf_d     = ovf_q;
        cmd_err_d = cmd_err_q;
        if (we && (reg_sel == REG_FILL)) fill_d = d[15:0];
        if (sts_wr && d[1]) ovf_d = 1'b0;
        if (sts_wr && d[2]) cmd_err_d = 1'b0;
        if (char_we && wb_full && !wb_pop) ovf_d = 1'b1;
        if (cmd_wr && engine_busy) cmd_err_d = 1'b1;
        spo_d = (reg_sel == REG_STATUS) ? {29'b0, cmd_err_q, ovf_q, engine_busy} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            last_q    <= '0;
            fill_q    <= FILL_RESET;
            ovf_q     <= 1'b0;
            cmd_err_q <= 1'b0;
            spo_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            last_q    <= last_d;
            fill_q    <= fill_d;
            ovf_q     <= ovf_d;
            cmd_err_q <= cmd_err_d;
            spo_q     <= spo_d;
        end
    end

    assign spo  = spo_q;
    assign busy = engine_busy;
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_console_blit_ctrl.sv
// Scoreboard bench for console_blit_ctrl with a 1-cycle-latency char RAM model.
module tb_console_blit_ctrl;
    import quasi_console_pkg::*;

    logic        clk, rst_n;
    logic [31:0] a, d, spo;
    logic        we;
    logic [11:0] char_a, ram_wa, ram_ra;
    logic [15:0] char_d, ram_wd, ram_rd;
    logic        char_we, ram_we, busy, done;

    console_blit_ctrl dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .spo(spo),
        .char_a(char_a), .char_d(char_d), .char_we(char_we),
        .ram_wa(ram_wa), .ram_wd(ram_wd), .ram_we(ram_we),
        .ram_ra(ram_ra), .ram_rd(ram_rd), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem [0:2399];
    logic        preload;
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < 2400; k++) mem[k] <= 16'(k);
        end else if (ram_we && ram_wa < 12'd2400) begin
            mem[ram_wa] <= ram_wd;
        end
        ram_rd <= (ram_ra < 12'd2400) ? mem[ram_ra] : 16'hDEAD;
    end

    int n_cmp, n_bad;
    logic [27:0] exp_q[$];
    logic [27:0] got_q[$];
    int sb_bad, sb_extra, cyc, done_cnt, done_cyc, busy_gap;
    logic [27:0] sb_first_got, sb_first_exp;

    function automatic logic [31:0] cmd(input logic [1:0] op, input logic [4:0] n);
        return {19'b0, n, 6'b0, op};
    endfunction

    // Record the current cycle's outputs against the expected-write queue, then advance.
    task automatic step();
        logic [27:0] e;
        if (ram_we) begin
            got_q.push_back({ram_wa, ram_wd});
            if (exp_q.size() == 0) begin
                sb_extra++;
            end else begin
                e = exp_q.pop_front();
                if (e !== {ram_wa, ram_wd}) begin
                    if (sb_bad == 0) begin
                        sb_first_got = {ram_wa, ram_wd};
                        sb_first_exp = e;
                    end
                    sb_bad++;
                end
            end
        end
        if (done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        if (!busy && !done && cyc > 0 && done_cnt == 0) busy_gap++;
        cyc++;
        @(negedge clk);
    endtask

    task automatic sb_reset();
        exp_q.delete();
        got_q.delete();
        sb_bad = 0; sb_extra = 0; cyc = 0; done_cnt = 0; done_cyc = -1; busy_gap = 0;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        a = addr; d = data; we = 1'b1;
        step();
        we = 1'b0; a = '0; d = '0;
    endtask

    task automatic read_status(output logic [31:0] v);
        a = 32'h8;
        step();
        v = spo;
        a = '0;
    endtask

    task automatic run_to_done(input int limit);
        while (done_cnt == 0 && cyc < limit) step();
    endtask

    task automatic push_fill(input int lo, input int hi, input logic [15:0] w);
        for (int k = lo; k <= hi; k++) exp_q.push_back({12'(k), w});
    endtask

    task automatic test_reset();
        logic [31:0] s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({spo, ram_we, ram_wa, ram_wd, ram_ra, busy, done} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got spo=%h we=%b wa=%h wd=%h ra=%h busy=%b done=%b, required all 0",
                     spo, ram_we, ram_wa, ram_wd, ram_ra, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        read_status(s);
        n_cmp++;
        if (s !== 32'h0) begin
            n_bad++; $display("FAIL reset_status: got %h required 00000000", s);
        end
        sb_reset();
        push_fill(0, 79, 16'h0F20);
        reg_write(32'h0, cmd(OP_FILLROW, 5'd0));
        run_to_done(200);
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_fill_row0: bad=%0d extra=%0d missing=%0d first got %h required %h",
                     sb_bad, sb_extra, exp_q.size(), sb_first_got, sb_first_exp);
        end
        n_cmp++;
        if (done_cyc != 81) begin
            n_bad++; $display("FAIL fillrow_latency: got done at %0d required 81", done_cyc);
        end
    endtask

    task automatic test_cpu_idle();
        char_a = 12'd7; char_d = 16'h1234; char_we = 1'b1;
        n_cmp++;
        if (ram_we !== 1'b0) begin
            n_bad++; $display("FAIL cpu_idle_early: got ram_we=%b required 0", ram_we);
        end
        step();
        char_we = 1'b0;
        n_cmp++;
        if ({ram_we, ram_wa, ram_wd} !== {1'b1, 12'd7, 16'h1234}) begin
            n_bad++;
            $display("FAIL cpu_idle_write: got we=%b wa=%h wd=%h required 1/007/1234", ram_we, ram_wa, ram_wd);
        end
        step();
        n_cmp++;
        if (ram_we !== 1'b0) begin
            n_bad++; $display("FAIL cpu_idle_single: got ram_we=%b required 0", ram_we);
        end
    endtask

    task automatic test_clear();
        reg_write(32'h4, 32'h0000_1741);
        sb_reset();
        push_fill(0, 2399, 16'h1741);
        reg_write(32'h0, cmd(OP_CLEAR, 5'd0));
        run_to_done(3000);
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL clear_writes: bad=%0d extra=%0d missing=%0d first got %h required %h",
                     sb_bad, sb_extra, exp_q.size(), sb_first_got, sb_first_exp);
        end
        n_cmp++;
        if (done_cyc != 2401 || busy_gap != 0) begin
            n_bad++;
            $display("FAIL clear_timing: got done at %0d busy gaps %0d required 2401 / 0", done_cyc, busy_gap);
        end
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL clear_done_pulse: got done=%b busy=%b after pulse required 0/0", done, busy);
        end
    endtask

    task automatic test_scroll();
        int bad;
        logic [15:0] want;
        reg_write(32'h4, 32'h0000_0720);
        preload = 1'b1;
        step();
        preload = 1'b0;
        sb_reset();
        for (int k = 0; k < 2240; k++) exp_q.push_back({12'(k), 16'(k + 160)});
        push_fill(2240, 2399, 16'h0720);
        reg_write(32'h0, cmd(OP_SCROLL, 5'd2));
        run_to_done(6000);
        step(); step();
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scroll2_writes: bad=%0d extra=%0d missing=%0d first got %h required %h",
                     sb_bad, sb_extra, exp_q.size(), sb_first_got, sb_first_exp);
        end
        n_cmp++;
        if (done_cyc != 4641 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL scroll2_done: got done at %0d count %0d required 4641 / 1", done_cyc, done_cnt);
        end
        bad = 0;
        for (int k = 0; k < 2400; k++) begin
            want = (k < 2240) ? 16'(k + 160) : 16'h0720;
            if (mem[k] !== want) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++; $display("FAIL scroll2_ram: got %0d wrong cells required 0", bad);
        end
    endtask

    task automatic test_scroll_edges();
        sb_reset();
        reg_write(32'h0, cmd(OP_SCROLL, 5'd0));
        run_to_done(20);
        n_cmp++;
        if (done_cyc != 1 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL scroll0: got done at %0d writes %0d required 1 / 0", done_cyc, got_q.size());
        end
        sb_reset();
        reg_write(32'h0, cmd(OP_FILLROW, 5'd30));
        run_to_done(20);
        n_cmp++;
        if (done_cyc != 1 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL fillrow30: got done at %0d writes %0d required 1 / 0", done_cyc, got_q.size());
        end
        sb_reset();
        reg_write(32'h0, cmd(OP_NOP, 5'd3));
        repeat (5) step();
        n_cmp++;
        if (done_cnt != 0 || got_q.size() != 0) begin
            n_bad++;
            $display("FAIL nop: got dones %0d writes %0d required 0 / 0", done_cnt, got_q.size());
        end
        sb_reset();
        push_fill(0, 2399, 16'h0720);
        reg_write(32'h0, cmd(OP_SCROLL, 5'd31));
        run_to_done(3000);
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0 || done_cyc != 2401) begin
            n_bad++;
            $display("FAIL scroll31: bad=%0d extra=%0d missing=%0d done at %0d required 0/0/0/2401",
                     sb_bad, sb_extra, exp_q.size(), done_cyc);
        end
    endtask

    task automatic test_cpu_during_clear();
        sb_reset();
        push_fill(0, 100, 16'h0720);
        exp_q.push_back({12'd5, 16'hABCD});
        push_fill(101, 2399, 16'h0720);
        reg_write(32'h0, cmd(OP_CLEAR, 5'd0));
        repeat (100) step();
        char_a = 12'd5; char_d = 16'hABCD; char_we = 1'b1;
        step();
        char_we = 1'b0;
        run_to_done(3000);
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL clear_cpu_writes: bad=%0d extra=%0d missing=%0d first got %h required %h",
                     sb_bad, sb_extra, exp_q.size(), sb_first_got, sb_first_exp);
        end
        n_cmp++;
        if (done_cyc != 2402 || mem[5] !== 16'hABCD) begin
            n_bad++;
            $display("FAIL clear_cpu_timing: got done at %0d cell5=%h required 2402 / abcd", done_cyc, mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int na, nb, nc, nd;
        logic [31:0] s;
        sb_reset();
        reg_write(32'h0, cmd(OP_SCROLL, 5'd2));
        while (!ram_we && cyc < 50) step();
        char_a = 12'd100; char_d = 16'hAAAA; char_we = 1'b1;
        step();
        char_a = 12'd101; char_d = 16'hBBBB;
        step();
        char_we = 1'b0;
        repeat (6) step();
        while (!ram_we && cyc < 100) step();
        step();
        char_a = 12'd102; char_d = 16'hCCCC; char_we = 1'b1;
        step();
        char_a = 12'd103; char_d = 16'hDDDD;
        step();
        char_we = 1'b0;
        run_to_done(8000);
        na = 0; nb = 0; nc = 0; nd = 0;
        foreach (got_q[i]) begin
            if (got_q[i] == {12'd100, 16'hAAAA}) na++;
            if (got_q[i] == {12'd101, 16'hBBBB}) nb++;
            if (got_q[i] == {12'd102, 16'hCCCC}) nc++;
            if (got_q[i] == {12'd103, 16'hDDDD}) nd++;
        end
        n_cmp++;
        if (na != 1 || nb != 1 || nc != 1 || nd != 0 || got_q.size() != 2403) begin
            n_bad++;
            $display("FAIL b2b_cpu_writes: got A=%0d B=%0d C=%0d D=%0d total=%0d required 1/1/1/0/2403",
                     na, nb, nc, nd, got_q.size());
        end
        read_status(s);
        n_cmp++;
        if (s !== 32'h2) begin
            n_bad++; $display("FAIL ovf_set: got status %h required 00000002", s);
        end
        reg_write(32'h8, 32'h2);
        read_status(s);
        n_cmp++;
        if (s !== 32'h0) begin
            n_bad++; $display("FAIL ovf_clear: got status %h required 00000000", s);
        end
    endtask

    task automatic test_cmd_err();
        logic [31:0] s;
        sb_reset();
        push_fill(240, 319, 16'h0720);
        reg_write(32'h0, cmd(OP_FILLROW, 5'd3));
        repeat (10) step();
        reg_write(32'h0, cmd(OP_CLEAR, 5'd0));
        run_to_done(300);
        n_cmp++;
        if (sb_bad != 0 || sb_extra != 0 || exp_q.size() != 0 || done_cyc != 81) begin
            n_bad++;
            $display("FAIL cmd_err_unaffected: bad=%0d extra=%0d missing=%0d done at %0d required 0/0/0/81",
                     sb_bad, sb_extra, exp_q.size(), done_cyc);
        end
        read_status(s);
        n_cmp++;
        if (s !== 32'h4) begin
            n_bad++; $display("FAIL cmd_err_set: got status %h required 00000004", s);
        end
        reg_write(32'h8, 32'h4);
        read_status(s);
        n_cmp++;
        if (s !== 32'h0) begin
            n_bad++; $display("FAIL cmd_err_clear: got status %h required 00000000", s);
        end
    endtask

    task automatic test_reset_abort();
        sb_reset();
        reg_write(32'h0, cmd(OP_SCROLL, 5'd2));
        repeat (50) step();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ram_we, busy, done, spo} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got we=%b busy=%b done=%b spo=%h required all 0", ram_we, busy, done, spo);
        end
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL abort_no_done: got dones %0d busy %b required 0 / 0", done_cnt, busy);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0;
        a = '0; d = '0; we = 1'b0;
        char_a = '0; char_d = '0; char_we = 1'b0;
        preload = 1'b0; rst_n = 1'b0;
        sb_reset();
        test_reset();
        test_cpu_idle();
        test_clear();
        test_scroll();
        test_scroll_edges();
        test_cpu_during_clear();
        test_back_to_back();
        test_cmd_err();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
